// File: rtl/grf_wb_pkg.sv
// Shared types and constants for the GRF write-back queue.
package grf_wb_pkg;

    localparam int WB_DEPTH = 4;
    localparam logic [4:0] REG_ZERO = 5'd0;

    typedef struct packed {
        logic [31:0] pc;
        logic [4:0]  addr;
        logic [31:0] data;
    } wb_entry_t;

endpackage

// File: rtl/grf_wb_fifo.sv
// Dual-push, single-pop circular queue of write-back entries.
// Entries are presented oldest-first: index 0 is the head.
module grf_wb_fifo
    import grf_wb_pkg::*;
#(
    parameter int DEPTH = WB_DEPTH
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      push_a_i,
    input  wb_entry_t                 entry_a_i,
    input  logic                      push_b_i,
    input  wb_entry_t                 entry_b_i,
    input  logic                      pop_i,
    output logic [$clog2(DEPTH):0]    count_o,
    output wb_entry_t [DEPTH-1:0]     entries_o,
    output logic [DEPTH-1:0]          valid_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    wb_entry_t        mem_q [DEPTH];
    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [PTR_W-1:0] tailPlusOne;
    logic             wr0En, wr1En;
    wb_entry_t        wr0Entry;
    logic [PTR_W-1:0] readIdx;

    // When only source B pushes, it takes the tail slot itself.
    always_comb begin
        wr0En       = push_a_i || push_b_i;
        wr1En       = push_a_i && push_b_i;
        wr0Entry    = push_a_i ? entry_a_i : entry_b_i;
        tailPlusOne = tail_q + PTR_W'(1);
        head_d      = pop_i ? head_q + PTR_W'(1) : head_q;
        tail_d      = tail_q + PTR_W'(push_a_i) + PTR_W'(push_b_i);
        count_d     = count_q + CNT_W'(push_a_i) + CNT_W'(push_b_i) - CNT_W'(pop_i);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            if (wr0En) mem_q[tail_q] <= wr0Entry;
            if (wr1En) mem_q[tailPlusOne] <= entry_b_i;
        end
    end

    always_comb begin
        readIdx   = '0;
        entries_o = '0;
        valid_o   = '0;
        for (int k = 0; k < DEPTH; k++) begin
            readIdx      = head_q + PTR_W'(k);
            entries_o[k] = mem_q[readIdx];
            valid_o[k]   = CNT_W'(k) < count_q;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/grf_writeback.sv
// GRF write-back arbiter: merges pipeline and MDU writes, retires one per cycle, offers bypass.
// Define GRF_WB_TRACE_EN to print a line per retired register write.
module grf_writeback
    import grf_wb_pkg::*;
#(
    parameter int DEPTH = WB_DEPTH
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        p_valid,
    input  logic [4:0]  p_addr,
    input  logic [31:0] p_data,
    input  logic [31:0] p_pc,
    output logic        p_stall,
    input  logic        m_valid,
    input  logic [4:0]  m_addr,
    input  logic [31:0] m_data,
    input  logic [31:0] m_pc,
    output logic        m_ready,
    output logic        gw_we,
    output logic [4:0]  gw_addr,
    output logic [31:0] gw_data,
    output logic [31:0] gw_pc,
    input  logic [4:0]  rs_addr,
    input  logic [4:0]  rt_addr,
    output logic        rs_hit,
    output logic        rt_hit,
    output logic [31:0] rs_data,
    output logic [31:0] rt_data
);

    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic [CNT_W-1:0]      count;
    logic [CNT_W-1:0]      free;
    logic                  pPush, mPush;
    wb_entry_t             pEntry, mEntry, headEntry;
    wb_entry_t [DEPTH-1:0] entries;
    logic [DEPTH-1:0]      valid;

    // Free space ignores this cycle's pop, so stall/ready are one entry conservative.
    assign free    = CNT_W'(DEPTH) - count;
    assign p_stall = free < CNT_W'(2);
    assign m_ready = (free >= CNT_W'(2)) || ((free >= CNT_W'(1)) && !p_valid);

    assign pPush  = p_valid && (p_addr != REG_ZERO);
    assign mPush  = m_valid && m_ready && (m_addr != REG_ZERO);
    assign pEntry = '{pc: p_pc, addr: p_addr, data: p_data};
    assign mEntry = '{pc: m_pc, addr: m_addr, data: m_data};

    grf_wb_fifo #(.DEPTH(DEPTH)) fifo (
        .clk       (clk),
        .reset     (reset),
        .push_a_i  (pPush),
        .entry_a_i (pEntry),
        .push_b_i  (mPush),
        .entry_b_i (mEntry),
        .pop_i     (gw_we),
        .count_o   (count),
        .entries_o (entries),
        .valid_o   (valid)
    );

    assign headEntry = entries[0];
    assign gw_we     = valid[0];
    assign gw_addr   = gw_we ? headEntry.addr : '0;
    assign gw_data   = gw_we ? headEntry.data : '0;
    assign gw_pc     = gw_we ? headEntry.pc   : '0;

    // Scanning oldest to newest lets the newest match overwrite older ones.
    always_comb begin
        rs_hit  = 1'b0;
        rt_hit  = 1'b0;
        rs_data = '0;
        rt_data = '0;
        for (int k = 0; k < DEPTH; k++) begin
            if (valid[k] && (rs_addr != REG_ZERO) && (entries[k].addr == rs_addr)) begin
                rs_hit  = 1'b1;
                rs_data = entries[k].data;
            end
            if (valid[k] && (rt_addr != REG_ZERO) && (entries[k].addr == rt_addr)) begin
                rt_hit  = 1'b1;
                rt_data = entries[k].data;
            end
        end
    end

`ifdef GRF_WB_TRACE_EN
    always @(posedge clk) begin
        if (reset && gw_we)
            $display("@%08h: $%2d <= %08h", gw_pc, gw_addr, gw_data);
    end
`else
`endif

endmodule

// File: doc/grf_writeback.md
# grf_writeback

Write-back request queue that owns the single GRF write port. Collects register write requests from the main pipeline W stage and from the multi-cycle multiply/divide unit, orders them, and retires exactly one per cycle onto the GRF write port. Also exposes a bypass lookup so decode-stage readers see values still pending in the queue.

## Interface
- DEPTH, 4: queue entries; power of two, ≥2
- clk  in  1  system clock, rising edge
- reset  in  1  synchronous, active-low; queue cleared when low at a clk edge
- p_valid  in  1  pipeline write request; legal only when p_stall is low
- p_addr  in  5  pipeline destination register
- p_data  in  32  pipeline write data
- p_pc  in  32  PC of the pipeline instruction
- p_stall  out  1  fewer than 2 free entries; upstream must hold p_valid low
- m_valid  in  1  MDU write request, held until accepted
- m_addr  in  5  MDU destination register
- m_data  in  32  MDU write data
- m_pc  in  32  PC of the MDU instruction
- m_ready  out  1  MDU request accepted this cycle when m_valid is also high
- gw_we  out  1  GRF write enable
- gw_addr  out  5  GRF write register
- gw_data  out  32  GRF write data
- gw_pc  out  32  PC for the write trace
- rs_addr, rt_addr  in  5 each  bypass lookup addresses
- rs_hit, rt_hit  out  1 each  a pending entry targets the address
- rs_data, rt_data  out  32 each  data of the newest pending matching entry; 0 when no hit

## Operation
- Circular FIFO: head and tail pointers of log2(DEPTH) bits wrapping at DEPTH; count of log2(DEPTH)+1 bits. free = DEPTH − count, evaluated before the current cycle's dequeue.
- Enqueue: a pipeline request is taken when p_valid is high. An MDU request is taken when m_valid && m_ready. If both are taken in the same cycle, the pipeline entry goes to the tail first and the MDU entry behind it, so the pipeline entry is older.
- Register 0: a request with addr 0 completes its handshake (m_ready is still honoured) but is not enqueued. gw_addr is therefore never 0 while gw_we is high.
- m_ready = (free ≥ 2) || (free ≥ 1 && !p_valid).
- p_stall = (free < 2).
- Dequeue: whenever count > 0, gw_* show the head entry combinationally with gw_we = 1. The head is popped at the next clk edge.
- Bypass: priority compare over valid entries from the newest to the oldest. An address of 0 never hits. Requests arriving in the same cycle are not visible to the lookup.
- p_valid while p_stall is high is a protocol violation. The bench flags it. The RTL behaviour in that case is undefined.

## Timing
- Reset, or any clk edge with reset low: count = 0, pointers = 0. Outputs that cycle: gw_we = 0, gw_addr/gw_data/gw_pc = 0, p_stall = 0, m_ready = 1, hits = 0. Pending entries are dropped even mid-stream.
- Latency: a request enqueued at edge N appears on gw_* after edge N and is written into the GRF at edge N+1. On an empty queue the minimum is 1 cycle from acceptance to GRF write.
- Throughput: one retirement per cycle. Sustained single-source input never backs up.
- Simultaneous enqueue and dequeue at full occupancy: the free calculation ignores the concurrent pop. Stall and ready decisions are conservative by one entry.
- Empty: gw_we = 0, and gw_addr/gw_data/gw_pc are driven to 0 rather than stale data.

## Configuration
- GRF_WB_TRACE_EN defined: each clk edge with gw_we high and reset high prints "@<gw_pc hex>: $<gw_addr decimal> <= <gw_data hex>", one line per retirement, in retirement order.
- GRF_WB_TRACE_EN undefined: no simulation output is produced. The logic is identical in both cases.

## Structure
- Shared package: wb_entry_t struct {pc[31:0], addr[4:0], data[31:0]}, the DEPTH default, and the REG_ZERO constant.
- One sub-module, grf_wb_fifo:
  - dual-push, single-pop storage holding pointers and count;
  - exposes all entries plus valid bits.
- The top level contains the arbitration, the register-0 filter, the stall/ready logic and the bypass compare.

## Test plan
- Reset low for 2 cycles, then release. All outputs hold their reset values. A single p_valid (addr 5, data 0x1234, pc 0x3000) gives gw_we = 1 with gw_addr = 5 exactly one cycle later.
- Same-cycle pipeline (addr 3, 0xA) and MDU (addr 3, 0xB) requests. Retirements are 0xA then 0xB on consecutive cycles. rs_addr = 3 reports hit with 0xB while both are pending.
- Request with addr 0 from each source. Both handshakes complete, gw_we stays 0, and rs_addr = 0 never hits.
- Hold m_valid continuously while pipeline requests arrive every cycle, DEPTH = 4. m_ready drops when free < 2, and p_stall rises exactly when count ≥ 3. Pointers wrap, no entry is lost, and output order matches acceptance order.
- Fill 3 entries, then assert reset low for one cycle. Next cycle gw_we = 0 and hits = 0, and none of the dropped entries are ever written.
- With GRF_WB_TRACE_EN defined, write addr 8 data 0xFF pc 0x3004. The log line reads "@00003004: $ 8 <= 000000ff".
